// File: rtl/cpu_port_responder.sv
// cpu_port_responder: responder end of the cpuAddr/cpustate/cpuena CPU port.
// Generates the 28 MHz / 7 MHz enable strobes from sysclk and serves CPU
// accesses from an internal 16-bit word RAM after LATENCY wait slots.
// Optional build macro CPU_RESP_PREFETCH_EN adds a one-entry next-word
// prefetch buffer that lets a sequential read skip its wait slots.
//
// state  | meaning
// S_IDLE | waiting for a valid request on an enaWRreg cycle
// S_WAIT | request captured, counting down wait slots
// S_ACK  | access done, cpuena high until the next enaWRreg cycle
module cpu_port_responder #(
    parameter int ADDR_W  = 12,
    parameter int LATENCY = 2,
    parameter int ENA_DIV = 4
) (
    input  logic          sysclk,
    input  logic          reset_in,
    input  logic [24:1]   cpuAddr,
    input  logic [6:0]    cpustate,
    input  logic          cpuL,
    input  logic          cpuU,
    input  logic [15:0]   cpuWR,
    output logic [15:0]   cpuRD,
    output logic          enaWRreg,
    output logic          ena7RDreg,
    output logic          ena7WRreg,
    output logic          cpuena
);

    localparam int               DIV_W    = $clog2(ENA_DIV);
    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(ENA_DIV - 1);
    localparam logic [DIV_W-1:0] DIV_PRE  = DIV_W'(ENA_DIV - 2);
    localparam logic [3:0]       LAT      = 4'(LATENCY);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_ACK  = 2'd2;

    logic [DIV_W-1:0]  r_div;
    logic [1:0]        r_slot;
    logic [1:0]        r_state;
    logic [3:0]        r_wait;
    logic [ADDR_W-1:0] r_idx;
    logic              r_write;
    logic [15:0]       r_data;
    logic              r_l;
    logic              r_u;
    logic [15:0]       r_ram [2**ADDR_W];

    logic              w_req_valid;
    logic              w_req_write;
    logic [ADDR_W-1:0] w_req_idx;
    logic              w_capture;
    logic              w_pf_hit;
    logic              w_go_ack;
    logic              w_from_inputs;
    logic              w_op_write;
    logic [ADDR_W-1:0] w_op_idx;
    logic [15:0]       w_op_data;
    logic              w_op_l;
    logic              w_op_u;
    logic              w_unused_bits;

    assign w_req_valid   = (cpustate[1:0] != 2'b01) && !cpustate[2];
    assign w_req_write   = (cpustate[1:0] == 2'b11);
    assign w_req_idx     = cpuAddr[ADDR_W:1];
    assign w_capture     = (r_state == S_IDLE) && enaWRreg && w_req_valid;
    assign w_unused_bits = ^{cpustate[6:3], cpuAddr[24:ADDR_W+1]};

    // When going straight from IDLE to ACK the operands come from the bus,
    // otherwise from the request captured earlier.
    assign w_from_inputs = (r_state == S_IDLE);
    assign w_op_write    = w_from_inputs ? w_req_write : r_write;
    assign w_op_idx      = w_from_inputs ? w_req_idx   : r_idx;
    assign w_op_data     = w_from_inputs ? cpuWR       : r_data;
    assign w_op_l        = w_from_inputs ? cpuL        : r_l;
    assign w_op_u        = w_from_inputs ? cpuU        : r_u;

`ifdef CPU_RESP_PREFETCH_EN
    logic              r_pf_valid;
    logic [ADDR_W-1:0] r_pf_idx;
    logic [15:0]       r_pf_data;
    logic [ADDR_W-1:0] w_pf_next;

    assign w_pf_next = w_op_idx + ADDR_W'(1);
    assign w_pf_hit  = w_capture && !w_req_write && r_pf_valid && (r_pf_idx == w_req_idx);

    // Prefetch buffer: refilled with the following word on every read, killed by writes to it.
    always_ff @(posedge sysclk) begin
        if (reset_in) begin
            r_pf_valid <= 1'b0;
            r_pf_idx   <= '0;
            r_pf_data  <= '0;
        end else if (w_go_ack) begin
            if (!w_op_write) begin
                r_pf_valid <= 1'b1;
                r_pf_idx   <= w_pf_next;
                r_pf_data  <= r_ram[w_pf_next];
            end else if (r_pf_idx == w_op_idx) begin
                r_pf_valid <= 1'b0;
            end
        end
    end
`else
    assign w_pf_hit = 1'b0;
`endif

    assign w_go_ack = (w_capture && ((LAT == 4'd0) || w_pf_hit)) ||
                      ((r_state == S_WAIT) && enaWRreg && (r_wait == 4'd1));

    // Strobe generator; strobes are registered so they line up with counter == ENA_DIV-1.
    always_ff @(posedge sysclk) begin
        if (reset_in) begin
            r_div     <= '0;
            r_slot    <= 2'd0;
            enaWRreg  <= 1'b0;
            ena7RDreg <= 1'b0;
            ena7WRreg <= 1'b0;
        end else begin
            r_div     <= (r_div == DIV_LAST) ? '0 : r_div + DIV_W'(1);
            enaWRreg  <= (r_div == DIV_PRE);
            ena7RDreg <= (r_div == DIV_PRE) && (r_slot == 2'd0);
            ena7WRreg <= (r_div == DIV_PRE) && (r_slot == 2'd2);
            if (enaWRreg) begin
                r_slot <= r_slot + 2'd1;
            end
        end
    end

    // Access sequencer: capture, wait slots, acknowledge, and read data return.
    always_ff @(posedge sysclk) begin
        if (reset_in) begin
            r_state <= S_IDLE;
            r_wait  <= 4'd0;
            r_idx   <= '0;
            r_write <= 1'b0;
            r_data  <= 16'h0000;
            r_l     <= 1'b1;
            r_u     <= 1'b1;
            cpuena  <= 1'b0;
            cpuRD   <= 16'h0000;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_capture) begin
                        r_idx   <= w_req_idx;
                        r_write <= w_req_write;
                        r_data  <= cpuWR;
                        r_l     <= cpuL;
                        r_u     <= cpuU;
                        r_wait  <= LAT;
                        r_state <= w_go_ack ? S_ACK : S_WAIT;
                        cpuena  <= w_go_ack;
                    end
                end
                S_WAIT: begin
                    if (w_go_ack) begin
                        r_state <= S_ACK;
                        cpuena  <= 1'b1;
                    end else if (enaWRreg) begin
                        r_wait <= r_wait - 4'd1;
                    end
                end
                S_ACK: begin
                    if (enaWRreg) begin
                        r_state <= S_IDLE;
                        cpuena  <= 1'b0;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    cpuena  <= 1'b0;
                end
            endcase
            if (w_go_ack && !w_op_write) begin
`ifdef CPU_RESP_PREFETCH_EN
                cpuRD <= w_pf_hit ? r_pf_data : r_ram[w_op_idx];
`else
                cpuRD <= r_ram[w_op_idx];
`endif
            end
        end
    end

    // Word RAM write on ACK entry, per byte lane; contents survive reset.
    always_ff @(posedge sysclk) begin
        if (w_go_ack && w_op_write && !reset_in) begin
            if (!w_op_l) begin
                r_ram[w_op_idx][7:0] <= w_op_data[7:0];
            end
            if (!w_op_u) begin
                r_ram[w_op_idx][15:8] <= w_op_data[15:8];
            end
        end
    end

endmodule
